// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM encodings for the memory responder.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DATA  = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;

  // A request is flagged when its beat size is not the full bus width or
  // its burst type is WRAP/reserved; it is still carried out as INCR.
  function automatic logic req_error(input logic [2:0] size,
                                     input logic [2:0] full_size,
                                     input logic [1:0] burst);
    return (size != full_size) || burst[1];
  endfunction

endpackage

// File: rtl/axi_mem_responder_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
// Read-first: a read and write of the same word in one cycle returns old data.
// Contents are deliberately not reset.
module axi_mem_responder_ram #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Byte-lane writes under the strobe mask.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Registered read; non-blocking ordering gives read-first behaviour.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory slave with independent write (AW/W/B) and read (AR/R) FSMs
// backed by a byte-enabled dual-port RAM. One transaction per direction.
// Handshakes: a beat transfers on a rising edge where VALID and READY are both
// high; once asserted, VALID and its payload hold until that transfer.
// dbg_w_state / dbg_r_state expose the FSM state registers.
module axi_mem_responder
  import axi_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH    = 8,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_M_AXI_WSTRB_WIDTH = C_M_AXI_DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH      = 10
) (
  input  logic                           ap_clk,
  input  logic                           reset,
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  s_AWADDR,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    s_AWID,
  input  logic [7:0]                     s_AWLEN,
  input  logic [2:0]                     s_AWSIZE,
  input  logic [1:0]                     s_AWBURST,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]  s_WDATA,
  input  logic [C_M_AXI_WSTRB_WIDTH-1:0] s_WSTRB,
  input  logic                           s_WLAST,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  output logic [C_M_AXI_ID_WIDTH-1:0]    s_BID,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]  s_ARADDR,
  input  logic [C_M_AXI_ID_WIDTH-1:0]    s_ARID,
  input  logic [7:0]                     s_ARLEN,
  input  logic [2:0]                     s_ARSIZE,
  input  logic [1:0]                     s_ARBURST,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]  s_RDATA,
  output logic                           s_RLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]    s_RID,
  output logic [1:0]                     s_RRESP,
  output logic [1:0]                     dbg_w_state,
  output logic [1:0]                     dbg_r_state
);

  localparam int B = $clog2(C_M_AXI_DATA_WIDTH / 8);
  localparam logic [2:0] FULL_SIZE = 3'(B);
  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = 1;
  localparam int IW = C_M_AXI_ID_WIDTH;
  localparam int MW = MEM_ADDR_WIDTH;

  // Held low through reset so READY outputs only rise one edge after release.
  logic live_q, live_d;

  logic [1:0]    w_state_q, w_state_d;
  logic [MW-1:0] w_idx_q, w_idx_d;
  logic [IW-1:0] w_id_q, w_id_d;
  logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic          w_fixed_q, w_fixed_d, w_err_q, w_err_d;
  logic          w_last;

  logic [1:0]    r_state_q, r_state_d;
  logic [MW-1:0] r_idx_q, r_idx_d, r_next;
  logic [IW-1:0] r_id_q, r_id_d;
  logic [7:0]    r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic          r_fixed_q, r_fixed_d, r_err_q, r_err_d;
  logic          r_last;

  logic [C_M_AXI_WSTRB_WIDTH-1:0] ram_we;
  logic [MW-1:0]                  ram_raddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]  ram_rdata;

  // Byte-offset and upper address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_AWADDR, s_ARADDR};

  assign live_d = 1'b1;
  assign w_last = (w_cnt_q == w_len_q);
  assign r_last = (r_cnt_q == r_len_q);
  assign r_next = r_fixed_q ? r_idx_q : r_idx_q + IDX_ONE;

  // Write FSM: accept AW, absorb LEN+1 beats into RAM, then answer on B.
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: if (live_q && s_AWVALID) begin
        w_idx_d   = s_AWADDR[MW+B-1:B];
        w_id_d    = s_AWID;
        w_len_d   = s_AWLEN;
        w_cnt_d   = 8'd0;
        w_fixed_d = (s_AWBURST == BURST_FIXED);
        w_err_d   = req_error(s_AWSIZE, FULL_SIZE, s_AWBURST);
        w_state_d = W_DATA;
      end
      W_DATA: if (s_WVALID) begin
        w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + IDX_ONE;
        w_cnt_d = w_cnt_q + 8'd1;
        // The beat count, not WLAST, decides the end; a disagreeing WLAST is an error.
        if (s_WLAST != w_last) w_err_d = 1'b1;
        if (w_last) w_state_d = W_RESP;
      end
      W_RESP: if (s_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: accept AR, spend one cycle fetching, then stream LEN+1 beats.
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      R_IDLE: if (live_q && s_ARVALID) begin
        r_idx_d   = s_ARADDR[MW+B-1:B];
        r_id_d    = s_ARID;
        r_len_d   = s_ARLEN;
        r_cnt_d   = 8'd0;
        r_fixed_d = (s_ARBURST == BURST_FIXED);
        r_err_d   = req_error(s_ARSIZE, FULL_SIZE, s_ARBURST);
        r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: if (s_RREADY) begin
        r_idx_d = r_next;
        r_cnt_d = r_cnt_q + 8'd1;
        if (r_last) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Control registers; reset discards any in-flight transaction.
  always_ff @(posedge ap_clk or posedge reset) begin
    if (reset) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_id_q    <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_id_q    <= r_id_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
    end
  end

  // Look ahead to the next word on an accepted beat so reads stream without bubbles.
  assign ram_raddr = (r_state_q == R_DATA && s_RREADY) ? r_next : r_idx_q;
  assign ram_we    = (w_state_q == W_DATA && s_WVALID) ? s_WSTRB : '0;

  axi_mem_responder_ram #(
    .DATA_WIDTH (C_M_AXI_DATA_WIDTH),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk   (ap_clk),
    .we    (ram_we),
    .waddr (w_idx_q),
    .wdata (s_WDATA),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign s_AWREADY   = live_q && (w_state_q == W_IDLE);
  assign s_WREADY    = (w_state_q == W_DATA);
  assign s_BVALID    = (w_state_q == W_RESP);
  assign s_BID       = w_id_q;
  assign s_BRESP     = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_ARREADY   = live_q && (r_state_q == R_IDLE);
  assign s_RVALID    = (r_state_q == R_DATA);
  assign s_RLAST     = (r_state_q == R_DATA) && r_last;
  assign s_RID       = r_id_q;
  assign s_RRESP     = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_RDATA     = ram_rdata;
  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;

endmodule
